hc595_chain_serializer: RTL and testbench

- Downstream stage of the 4x7-seg segment encoder. Takes one parallel frame of 8*NUM_ICS bits (segment pattern plus digit select) and shifts it out serially to a daisy-chain of 74HC595 shift registers.
- Generates the three board pins SCLK, DATA and LATCH, then reports completion.
- Sits between the segment encoder and the top-level io_out[2:0] pins.
- Runs on the system clock (8.192 kHz on the clock board) with a configurable SCLK divider.

---
 rtl/hc595_pkg.sv | 20 ++
 rtl/hc595_phase_timer.sv | 29 ++
 rtl/hc595_chain_serializer.sv | 113 +++++++++++
 tb/tb_hc595_chain_serializer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hc595_pkg.sv
// Shared types and constants for the 74HC595 daisy-chain serializer and its
// phase timer.
package hc595_pkg;

  localparam int BITS_PER_IC = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  // Clock cycles from an accept edge to the end of the done cycle, which is
  // also the frame period when the trigger is held high.
  function automatic int frame_cycles(input int num_ics, input int clk_div);
    return 2 * clk_div * num_ics * BITS_PER_IC + clk_div + 1;
  endfunction

endpackage

// File: rtl/hc595_phase_timer.sv
// Phase timer: pulses phase_done_o on the last cycle of every CLK_DIV-cycle
// phase while running, then restarts for the next phase.
module hc595_phase_timer #(
  parameter int CLK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic run_i,
  output logic phase_done_o
);

  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] div_cnt;

  assign phase_done_o = run_i && (div_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_cnt <= '0;
    end else if (load_i || !run_i || phase_done_o) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/hc595_chain_serializer.sv
// Shifts one 8*NUM_ICS-bit frame into a chain of 74HC595s: SCLK rises
// mid-bit, followed by a single LATCH pulse and a one-cycle done_o.
module hc595_chain_serializer
  import hc595_pkg::*;
#(
  parameter int NUM_ICS   = 2,
  parameter int CLK_DIV   = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         trigger_i,
  input  logic [BITS_PER_IC*NUM_ICS-1:0] data_i,
  output logic                         ready_o,
  output logic                         done_o,
  output logic                         sclk_o,
  output logic                         data_o,
  output logic                         latch_en_o
);

  localparam int N  = BITS_PER_IC * NUM_ICS;
  localparam int BW = $clog2(N);

  state_t        state, state_n;
  logic [N-1:0]  shadow, shadow_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic          accept, phase_done, last_bit;
  logic          done_n, sclk_n, data_n, latch_n;

  function automatic logic head_bit(input logic [N-1:0] v);
    return MSB_FIRST ? v[N-1] : v[0];
  endfunction

  function automatic logic [N-1:0] shift_frame(input logic [N-1:0] v);
    return MSB_FIRST ? {v[N-2:0], 1'b0} : {1'b0, v[N-1:1]};
  endfunction

  assign ready_o  = (state == IDLE);
  assign accept   = trigger_i && ready_o;
  assign last_bit = (bit_cnt == BW'(N - 1));

  hc595_phase_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_phase_timer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (accept),
    .run_i       (state != IDLE),
    .phase_done_o(phase_done)
  );

  always_comb begin
    state_n   = state;
    shadow_n  = shadow;
    bit_cnt_n = bit_cnt;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          shadow_n  = data_i;
          bit_cnt_n = '0;
          state_n   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (phase_done) state_n = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (phase_done) begin
          if (last_bit) begin
            state_n = LATCH;
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
            shadow_n  = shift_frame(shadow);
            state_n   = SHIFT_LO;
          end
        end
      end
      LATCH: begin
        if (phase_done) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Pins are decoded from the next state so they change together with it.
    sclk_n  = (state_n == SHIFT_HI);
    latch_n = (state_n == LATCH);
    data_n  = (state_n != IDLE) ? head_bit(shadow_n) : 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= IDLE;
      shadow     <= '0;
      bit_cnt    <= '0;
      done_o     <= 1'b0;
      sclk_o     <= 1'b0;
      data_o     <= 1'b0;
      latch_en_o <= 1'b0;
    end else begin
      state      <= state_n;
      shadow     <= shadow_n;
      bit_cnt    <= bit_cnt_n;
      done_o     <= done_n;
      sclk_o     <= sclk_n;
      data_o     <= data_n;
      latch_en_o <= latch_n;
    end
  end

endmodule

// File: tb/tb_hc595_chain_serializer.sv
// Directed bench for hc595_chain_serializer: default chain (2 ICs, CLK_DIV=1)
// plus a single-IC instance with CLK_DIV=3.
module tb_hc595_chain_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b0, trig_a = 1'b0;
  logic [15:0] data_a = '0;
  logic        ready_a, done_a, sclk_a, dout_a, latch_a;

  logic        rst_b = 1'b0, trig_b = 1'b0;
  logic [7:0]  data_b = '0;
  logic        ready_b, done_b, sclk_b, dout_b, latch_b;

  int total = 0;
  int bad   = 0;

  hc595_chain_serializer #(.NUM_ICS(2), .CLK_DIV(1), .MSB_FIRST(1'b1)) dut_a (
    .clk_i(clk), .rst_ni(rst_a), .trigger_i(trig_a), .data_i(data_a),
    .ready_o(ready_a), .done_o(done_a), .sclk_o(sclk_a), .data_o(dout_a),
    .latch_en_o(latch_a)
  );

  hc595_chain_serializer #(.NUM_ICS(1), .CLK_DIV(3), .MSB_FIRST(1'b1)) dut_b (
    .clk_i(clk), .rst_ni(rst_b), .trigger_i(trig_b), .data_i(data_b),
    .ready_o(ready_b), .done_o(done_b), .sclk_o(sclk_b), .data_o(dout_b),
    .latch_en_o(latch_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] val(input int c);
    logic [15:0] cc;
    cc = 16'(c);
    return (cc * 16'h0713) ^ 16'h5A5A;
  endfunction

  // Observes DUT A for ncyc cycles after an accept edge (cycle 1 onward).
  task automatic watch_a(input int ncyc, input bit busy_pulses,
                         output logic [15:0] bits, output int rises,
                         output int lat_n, output int lat_first,
                         output int done_n, output int done_first);
    logic prev;
    prev = 1'b0; bits = '0; rises = 0;
    lat_n = 0; lat_first = -1; done_n = 0; done_first = -1;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      if (c == 1) trig_a = 1'b0;
      if (busy_pulses) begin
        if (c == 5)  begin trig_a = 1'b1; data_a = 16'h0F0F; end
        if (c == 20) begin trig_a = 1'b1; data_a = 16'hFFFF; end
        if (c == 6 || c == 21) trig_a = 1'b0;
      end
      if (sclk_a && !prev) begin
        rises++;
        bits = {bits[14:0], dout_a};
      end
      prev = sclk_a;
      if (latch_a) begin lat_n++;  if (lat_first < 0)  lat_first = c; end
      if (done_a)  begin done_n++; if (done_first < 0) done_first = c; end
    end
  endtask

  initial begin
    logic [15:0] bits, frames [3];
    logic [7:0]  bits_b;
    logic        prev, prev_l, any_pin, all_ready;
    int rises, lat_n, lat_first, done_n, done_first, lat_rises;
    int hi_cyc, first_rise, last_rise;

    // Reset then idle
    step(); step();
    chk("reset_pins_a", {ready_a, done_a, sclk_a, dout_a, latch_a}, 5'b10000);
    chk("reset_pins_b", {ready_b, done_b, sclk_b, dout_b, latch_b}, 5'b10000);
    rst_a = 1'b1; rst_b = 1'b1;
    any_pin = 1'b0; all_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      any_pin   = any_pin | done_a | sclk_a | dout_a | latch_a;
      all_ready = all_ready & ready_a;
    end
    chk("idle_pins_low", any_pin, 1'b0);
    chk("idle_ready", all_ready, 1'b1);

    // Single frame, defaults
    data_a = 16'hA5C3; trig_a = 1'b1;
    watch_a(40, 1'b0, bits, rises, lat_n, lat_first, done_n, done_first);
    chk("single_bits", bits, 16'hA5C3);
    chk("single_rises", rises, 16);
    chk("single_latch_n", lat_n, 1);
    chk("single_latch_cycle", lat_first, 33);
    chk("single_done_n", done_n, 1);
    chk("single_done_cycle", done_first, 34);
    chk("single_ready_after", ready_a, 1'b1);

    // Continuous trigger with data changing every cycle
    data_a = val(0); trig_a = 1'b1;
    prev = 1'b0; prev_l = 1'b0; rises = 0; lat_rises = 0; done_n = 0;
    frames[0] = '0; frames[1] = '0; frames[2] = '0;
    for (int c = 1; c <= 102; c++) begin
      step();
      data_a = val(c);
      if (c == 102) trig_a = 1'b0;
      if (sclk_a && !prev) begin
        if (rises < 48) frames[rises / 16] = {frames[rises / 16][14:0], dout_a};
        rises++;
      end
      prev = sclk_a;
      if (latch_a && !prev_l) lat_rises++;
      prev_l = latch_a;
      if (done_a) done_n++;
    end
    chk("cont_rises", rises, 48);
    chk("cont_latch_pulses", lat_rises, 3);
    chk("cont_done_pulses", done_n, 3);
    chk("cont_frame0", frames[0], val(0));
    chk("cont_frame1", frames[1], val(34));
    chk("cont_frame2", frames[2], val(68));
    for (int i = 0; i < 4; i++) step();
    chk("cont_stopped", {ready_a, sclk_a, latch_a}, 3'b100);

    // CLK_DIV=3, one IC
    data_b = 8'h81; trig_b = 1'b1;
    prev = 1'b0; bits_b = '0; rises = 0; hi_cyc = 0; first_rise = -1; last_rise = -1;
    lat_n = 0; lat_first = -1; done_n = 0; done_first = -1;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (c == 1) trig_b = 1'b0;
      if (sclk_b) hi_cyc++;
      if (sclk_b && !prev) begin
        rises++;
        bits_b = {bits_b[6:0], dout_b};
        if (first_rise < 0) first_rise = c;
        last_rise = c;
      end
      prev = sclk_b;
      if (latch_b) begin lat_n++;  if (lat_first < 0)  lat_first = c; end
      if (done_b)  begin done_n++; if (done_first < 0) done_first = c; end
    end
    chk("div3_bits", bits_b, 8'h81);
    chk("div3_rises", rises, 8);
    chk("div3_first_rise", first_rise, 4);
    chk("div3_last_rise", last_rise, 46);
    chk("div3_sclk_hi_cycles", hi_cyc, 24);
    chk("div3_latch_n", lat_n, 3);
    chk("div3_latch_first", lat_first, 49);
    chk("div3_done_n", done_n, 1);
    chk("div3_done_cycle", done_first, 52);

    // Reset mid-frame
    data_a = 16'hFFFF; trig_a = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) trig_a = 1'b0;
    end
    chk("midrst_active", {ready_a, sclk_a, dout_a}, 3'b011);
    rst_a = 1'b0;
    step();
    chk("midrst_pins", {done_a, sclk_a, dout_a, latch_a}, 4'b0000);
    rst_a = 1'b1;
    watch_a(40, 1'b0, bits, rises, lat_n, lat_first, done_n, done_first);
    chk("midrst_no_sclk", rises, 0);
    chk("midrst_no_latch", lat_n, 0);
    chk("midrst_no_done", done_n, 0);
    chk("midrst_ready", ready_a, 1'b1);

    // Trigger while busy
    data_a = 16'h3C96; trig_a = 1'b1;
    watch_a(60, 1'b1, bits, rises, lat_n, lat_first, done_n, done_first);
    chk("busy_bits", bits, 16'h3C96);
    chk("busy_rises", rises, 16);
    chk("busy_latch_n", lat_n, 1);
    chk("busy_done_cycle", done_first, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
